// File: rtl/disp_scan_if.sv
// disp_scan_if: signal bundle between a 4-digit 7-segment scanner and its host.
//   data_i  [15:0] four hex digits, digit k = data_i[4k+3:4k]
//   dot_i   [3:0]  decimal point per digit
//   en_i    [3:0]  digit enable, 0 blanks the digit
//   segment [7:0]  segment drive, bit0..6 = a..g, bit7 = dp
//   anode   [3:0]  one-hot digit select
//   frame_o        one-cycle pulse when a new input frame is latched
// master = host side (drives inputs), slave = scanner side.
interface disp_scan_if;
  logic [15:0] data_i;
  logic [3:0]  dot_i;
  logic [3:0]  en_i;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_o;

  modport master (
    output data_i,
    output dot_i,
    output en_i,
    input  segment,
    input  anode,
    input  frame_o
  );

  modport slave (
    input  data_i,
    input  dot_i,
    input  en_i,
    output segment,
    output anode,
    output frame_o
  );
endinterface

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed driver for a 4-digit 7-segment display.
// Each digit is shown for CLK_FREQ*SCAN_US clock cycles. Inputs are captured
// into shadow registers once per frame (on the 3->0 digit wrap) so a frame is
// never torn by host updates. All outputs are registered.
//   clk  main clock, rising edge
//   rst  asynchronous active-low reset
//   bus  disp_scan_if slave modport (data/dot/en in, segment/anode/frame out)
module disp_scan #(
  parameter int unsigned CLK_FREQ   = 100,
  parameter int unsigned SCAN_US    = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int unsigned CLK_COUNT = CLK_FREQ * SCAN_US;
  // Width of CLK_COUNT-1; a single-cycle dwell still needs a 1-bit counter.
  localparam int unsigned CntW      = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_COUNT - 1);
  localparam logic [7:0] SegOff     = {8{ACTIVE_LOW}};
  localparam logic [3:0] AnOff      = {4{ACTIVE_LOW}};

  logic [CntW-1:0] presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     sh_data_q;
  logic [3:0]      sh_dot_q, sh_en_q;
  logic            frame_q;
  logic [7:0]      segment_q, segment_d;
  logic [3:0]      anode_q, anode_d;

  logic            tick;
  logic            wrap;
  logic [3:0]      nibble;
  logic [6:0]      pattern;
  logic            digit_on;

  always_comb begin
    tick    = (presc_q == CntMax);
    wrap    = tick && (idx_q == 2'd3);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    nibble   = sh_data_q[{idx_q, 2'b00} +: 4];
    digit_on = sh_en_q[idx_q];

    case (nibble)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase

    // Blanked digit drops everything including the dp and its anode.
    if (digit_on) begin
      segment_d = {sh_dot_q[idx_q], pattern};
      anode_d   = 4'(4'b0001 << idx_q);
    end else begin
      segment_d = 8'h00;
      anode_d   = 4'h0;
    end
    segment_d = segment_d ^ SegOff;
    anode_d   = anode_d ^ AnOff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      sh_data_q <= 16'h0000;
      sh_dot_q  <= 4'h0;
      sh_en_q   <= 4'h0;
      frame_q   <= 1'b0;
      segment_q <= SegOff;
      anode_q   <= AnOff;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      frame_q   <= wrap;
      segment_q <= segment_d;
      anode_q   <= anode_d;
      if (wrap) begin
        sh_data_q <= bus.data_i;
        sh_dot_q  <= bus.dot_i;
        sh_en_q   <= bus.en_i;
      end
    end
  end

  assign bus.segment = segment_q;
  assign bus.anode   = anode_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed bench for disp_scan with a per-cycle scoreboard.
// DUT a: CLK_COUNT=4, active low. DUT b: CLK_COUNT=4, active high.
// DUT c: CLK_COUNT=1, active low (index advances every cycle).
module tb_disp_scan;

  typedef logic [12:0] ent_t; // {frame, anode, segment}

  logic clk = 1'b0;
  logic rst_a;
  logic rst_bc;

  disp_scan_if ifa ();
  disp_scan_if ifb ();
  disp_scan_if ifc ();

  disp_scan #(.CLK_FREQ(1), .SCAN_US(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  disp_scan #(.CLK_FREQ(1), .SCAN_US(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk (clk),
    .rst (rst_bc),
    .bus (ifb)
  );

  disp_scan #(.CLK_FREQ(1), .SCAN_US(1), .ACTIVE_LOW(1'b1)) dut_c (
    .clk (clk),
    .rst (rst_bc),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  ent_t qa[$];
  ent_t qb[$];
  ent_t qc[$];
  bit   act_a, act_b, act_c;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  function automatic logic [11:0] model(input logic [15:0] d, input logic [3:0] dt,
                                        input logic [3:0] en, input int k, input bit al);
    logic [3:0] nib;
    logic [6:0] p;
    logic [7:0] s;
    logic [3:0] a;
    nib = d[k*4 +: 4];
    case (nib)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    if (en[k]) begin
      s = {dt[k], p};
      a = 4'(4'b0001 << k);
    end else begin
      s = 8'h00;
      a = 4'h0;
    end
    if (al) begin
      s = ~s;
      a = ~a;
    end
    return {a, s};
  endfunction

  task automatic push(input int sel, input ent_t e);
    case (sel)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // n blank cycles; the last one carries the latch pulse.
  task automatic push_blank(input int sel, input bit al, input int n);
    for (int i = 0; i < n; i++)
      push(sel, {(i == n - 1), (al ? 4'hF : 4'h0), (al ? 8'hFF : 8'h00)});
  endtask

  // One full frame of a latched value, cc cycles per digit.
  task automatic push_frame(input int sel, input logic [15:0] d, input logic [3:0] dt,
                            input logic [3:0] en, input bit al, input int cc);
    for (int i = 0; i < 4 * cc; i++)
      push(sel, {(i == 4 * cc - 1), model(d, dt, en, i / cc, al)});
  endtask

  task automatic check(input string tag, input ent_t obs, input ent_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed={fr=%b an=%h seg=%h} expected={fr=%b an=%h seg=%h}",
             tag, cyc, obs[12], obs[11:8], obs[7:0], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic pop_check(input string tag, input ent_t obs, input int sel);
    ent_t e;
    int   sz;
    sz = (sel == 0) ? qa.size() : (sel == 1) ? qb.size() : qc.size();
    if (sz == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_underflow cyc=%0d observed=%h expected=none", tag, cyc, obs);
    end else begin
      case (sel)
        0:       e = qa.pop_front();
        1:       e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      check(tag, obs, e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (act_a) pop_check("a", {ifa.frame_o, ifa.anode, ifa.segment}, 0);
      if (act_b) pop_check("b", {ifb.frame_o, ifb.anode, ifb.segment}, 1);
      if (act_c) pop_check("c", {ifc.frame_o, ifc.anode, ifc.segment}, 2);
    end
  endtask

  initial begin
    act_a = 1'b0; act_b = 1'b0; act_c = 1'b0;
    rst_a = 1'b1; rst_bc = 1'b1;
    ifa.data_i = 16'h0; ifa.dot_i = 4'h0; ifa.en_i = 4'h0;
    ifb.data_i = 16'h0; ifb.dot_i = 4'h0; ifb.en_i = 4'h0;
    ifc.data_i = 16'h0; ifc.dot_i = 4'h0; ifc.en_i = 4'h0;

    // Asynchronous reset before any clock edge.
    #2;
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    #1;
    check("rst_async", {ifa.frame_o, ifa.anode, ifa.segment}, {1'b0, 4'hF, 8'hFF});

    // Held reset ignores clock and input activity.
    ifa.en_i = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #1;
      ifa.data_i = ifa.data_i ^ 16'hA5A5;
      ifa.dot_i  = ~ifa.dot_i;
      check("rst_hold", {ifa.frame_o, ifa.anode, ifa.segment}, {1'b0, 4'hF, 8'hFF});
    end

    // First frame after release, then mid-frame data change.
    @(negedge clk);
    ifa.data_i = 16'h1234; ifa.dot_i = 4'h0; ifa.en_i = 4'hF;
    rst_a = 1'b1;
    act_a = 1'b1;
    push_blank(0, 1'b1, 16);
    push_frame(0, 16'h1234, 4'h0, 4'hF, 1'b1, 4);
    push_frame(0, 16'h8888, 4'h0, 4'hF, 1'b1, 4);
    run(16);
    run(6);
    ifa.data_i = 16'h8888;
    run(10);

    // Blanking and dot, changed while the 8888 frame is on screen.
    push_frame(0, 16'h000F, 4'h1, 4'h5, 1'b1, 4);
    run(3);
    ifa.data_i = 16'h000F; ifa.dot_i = 4'h1; ifa.en_i = 4'h5;
    run(13);
    run(16);

    // Reset during the second digit discards the frame.
    push_frame(0, 16'h000F, 4'h1, 4'h5, 1'b1, 4);
    run(5);
    rst_a = 1'b0;
    #1;
    check("rst_mid", {ifa.frame_o, ifa.anode, ifa.segment}, {1'b0, 4'hF, 8'hFF});
    qa.delete();
    act_a = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_mid_hold", {ifa.frame_o, ifa.anode, ifa.segment}, {1'b0, 4'hF, 8'hFF});
    end
    @(negedge clk);
    rst_a = 1'b1;
    act_a = 1'b1;
    push_blank(0, 1'b1, 16);
    push_frame(0, 16'h000F, 4'h1, 4'h5, 1'b1, 4);
    run(32);
    act_a = 1'b0;

    // Active-high polarity (b) and single-cycle dwell (c).
    check("b_in_reset", {ifb.frame_o, ifb.anode, ifb.segment}, {1'b0, 4'h0, 8'h00});
    @(negedge clk);
    ifb.data_i = 16'h0000; ifb.dot_i = 4'h0; ifb.en_i = 4'hF;
    ifc.data_i = 16'h1234; ifc.dot_i = 4'h0; ifc.en_i = 4'hF;
    rst_bc = 1'b1;
    act_b  = 1'b1;
    act_c  = 1'b1;
    push_blank(1, 1'b0, 16);
    push_frame(1, 16'h0000, 4'h0, 4'hF, 1'b0, 4);
    push_blank(2, 1'b1, 4);
    for (int i = 0; i < 7; i++) push_frame(2, 16'h1234, 4'h0, 4'hF, 1'b1, 1);
    run(32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
